// File: rtl/store_sink_fifo.sv
// store_sink_fifo: snoops core stores, queues those landing in an output window and
// latches the store to RESULT_ADDR into a sticky result register.
module store_sink_fifo #(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h20,
    parameter int          WIN_WORDS   = 4,
    parameter logic [31:0] RESULT_ADDR = 32'h24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_write,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [$clog2(WIN_WORDS)-1:0] out_offset,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       result_valid,
    output logic [31:0]                result_value,
    output logic                       overflow,
    output logic                       misalign_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(WIN_WORDS);
    localparam logic [31:0] WIN_END = BASE_ADDR + 32'(4 * WIN_WORDS);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   data_mem [DEPTH];
    logic [OW-1:0] off_mem  [DEPTH];
    logic [31:0]   rel;
    logic          hit, aligned, push_req, pop, full, push;
    logic          unused_rel;
    assign rel        = mem_addr - BASE_ADDR;
    assign unused_rel = ^{rel[31:OW+2], rel[1:0]};
    assign hit        = mem_write && mem_addr >= BASE_ADDR && mem_addr < WIN_END;
    assign aligned    = mem_addr[1:0] == 2'b00;
    assign push_req   = hit && aligned;
    assign full       = count == (AW+1)'(DEPTH);
    assign pop        = count != '0 && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!full || pop);
    assign out_valid  = count != '0;
    assign out_data   = out_valid ? data_mem[rd_ptr] : '0;
    assign out_offset = out_valid ? off_mem[rd_ptr] : '0;
    assign fifo_count = count;
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_wdata;
            off_mem[wr_ptr]  <= rel[OW+1:2];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            result_valid <= 1'b0;
            result_value <= '0;
            overflow     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push_req && !push)
                overflow <= 1'b1;
            if (hit && !aligned)
                misalign_err <= 1'b1;
            if (mem_write && mem_addr == RESULT_ADDR) begin
                result_valid <= 1'b1;
                result_value <= mem_wdata;
            end
        end
    end
endmodule

// File: tb/tb_store_sink_fifo.sv
// tb_store_sink_fifo: directed vector table, reset-mid-drain sequence, and
// randomized stores checked against a queue-based reference model.
module tb_store_sink_fifo;
    logic        clk = 0, reset = 1, mem_write = 0, out_ready = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0;
    logic        out_valid, result_valid, overflow, misalign_err;
    logic [31:0] out_data, result_value;
    logic [1:0]  out_offset;
    logic [2:0]  fifo_count;
    int tests = 0, fails = 0;

    store_sink_fifo dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_offset(out_offset), .fifo_count(fifo_count),
        .result_valid(result_valid), .result_value(result_value),
        .overflow(overflow), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, mw; logic [31:0] a, d; logic rdy;
        logic ev; logic [31:0] ed; logic [1:0] eo; logic [2:0] ec;
        logic erv; logic [31:0] er; logic eov, emi;
    } vec_t;
    vec_t vq[$];

    logic [33:0] mq[$];
    logic        m_rvv, m_ovf, m_mis;
    logic [31:0] m_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic ev, input logic [31:0] ed, input logic [1:0] eo,
                       input logic [2:0] ec, input logic erv, input logic [31:0] er,
                       input logic eov, input logic emi);
        vec_t t;
        t.rst = rst; t.mw = mw; t.a = a; t.d = d; t.rdy = rdy;
        t.ev = ev; t.ed = ed; t.eo = eo; t.ec = ec;
        t.erv = erv; t.er = er; t.eov = eov; t.emi = emi;
        vq.push_back(t);
    endtask

    // Reference: a queue of {offset,data}; a pop leaves before the push is judged for room.
    task automatic model_step(input logic rst, input logic mw, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy);
        logic in_win, popped;
        if (rst) begin
            mq.delete(); m_rvv = 0; m_rv = 0; m_ovf = 0; m_mis = 0;
            return;
        end
        in_win = mw && a >= 32'h20 && a < 32'h30;
        popped = mq.size() != 0 && rdy;
        if (mw && a == 32'h24) begin m_rvv = 1; m_rv = d; end
        if (popped) void'(mq.pop_front());
        if (in_win && a[1:0] != 0) m_mis = 1;
        else if (in_win) begin
            if (mq.size() < 4) mq.push_back({2'((a - 32'h20) / 4), d});
            else m_ovf = 1;
        end
    endtask

    task automatic apply(input logic rst, input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        reset = rst; mem_write = mw; mem_addr = a; mem_wdata = d; out_ready = rdy;
        model_step(rst, mw, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("rnd_count", 32'(fifo_count), 32'(mq.size()));
        chk("rnd_data", out_data, mq.size() != 0 ? mq[0][31:0] : 32'h0);
        chk("rnd_offset", 32'(out_offset), mq.size() != 0 ? 32'(mq[0][33:32]) : 32'h0);
        chk("rnd_rvalid", 32'(result_valid), 32'(m_rvv));
        chk("rnd_rvalue", result_value, m_rv);
        chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
        chk("rnd_misalign", 32'(misalign_err), 32'(m_mis));
    endtask

    initial begin
        // reset and release
        add(1,0,0,0,0, 0,0,0,0, 0,0,0,0);
        add(1,0,0,0,0, 0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0, 0,0,0,0);
        // result word store, then pop
        add(0,1,32'h24,32'hFFFFFFF6,1, 1,32'hFFFFFFF6,1,1, 1,32'hFFFFFFF6,0,0);
        add(0,0,0,0,1, 0,0,0,0, 1,32'hFFFFFFF6,0,0);
        // fill, overflow, drain
        add(0,1,32'h20,1,0, 1,1,0,1, 1,32'hFFFFFFF6,0,0);
        add(0,1,32'h24,2,0, 1,1,0,2, 1,2,0,0);
        add(0,1,32'h28,3,0, 1,1,0,3, 1,2,0,0);
        add(0,1,32'h2C,4,0, 1,1,0,4, 1,2,0,0);
        add(0,1,32'h20,5,0, 1,1,0,4, 1,2,1,0);
        add(0,0,0,0,1, 1,2,1,3, 1,2,1,0);
        add(0,0,0,0,1, 1,3,2,2, 1,2,1,0);
        add(0,0,0,0,1, 1,4,3,1, 1,2,1,0);
        add(0,0,0,0,1, 0,0,0,0, 1,2,1,0);
        // full with simultaneous push and pop
        add(1,0,0,0,0, 0,0,0,0, 0,0,0,0);
        add(0,1,32'h20,1,0, 1,1,0,1, 0,0,0,0);
        add(0,1,32'h24,2,0, 1,1,0,2, 1,2,0,0);
        add(0,1,32'h28,3,0, 1,1,0,3, 1,2,0,0);
        add(0,1,32'h2C,4,0, 1,1,0,4, 1,2,0,0);
        add(0,1,32'h28,7,1, 1,2,1,4, 1,2,0,0);
        add(0,0,0,0,1, 1,3,2,3, 1,2,0,0);
        add(0,0,0,0,1, 1,4,3,2, 1,2,0,0);
        add(0,0,0,0,1, 1,7,2,1, 1,2,0,0);
        add(0,0,0,0,1, 0,0,0,0, 1,2,0,0);
        // misaligned in-window and out-of-window stores
        add(0,1,32'h22,9,0, 0,0,0,0, 1,2,0,1);
        add(0,1,32'h40,9,0, 0,0,0,0, 1,2,0,1);
        add(0,1,32'h1C,9,0, 0,0,0,0, 1,2,0,1);
        add(0,1,32'h30,9,0, 0,0,0,0, 1,2,0,1);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].mw, vq[i].a, vq[i].d, vq[i].rdy);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].ev));
            chk($sformatf("v%0d_data", i), out_data, vq[i].ed);
            chk($sformatf("v%0d_offset", i), 32'(out_offset), 32'(vq[i].eo));
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vq[i].ec));
            chk($sformatf("v%0d_rvalid", i), 32'(result_valid), 32'(vq[i].erv));
            chk($sformatf("v%0d_rvalue", i), result_value, vq[i].er);
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vq[i].eov));
            chk($sformatf("v%0d_misalign", i), 32'(misalign_err), 32'(vq[i].emi));
        end

        // reset mid-drain, then a fresh store
        apply(0,1,32'h20,32'hA,0);
        apply(0,1,32'h24,32'hB,0);
        chk("mid_count_before", 32'(fifo_count), 2);
        apply(1,0,0,0,1);
        chk("mid_count", 32'(fifo_count), 0);
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_rvalid", 32'(result_valid), 0);
        chk("mid_rvalue", result_value, 0);
        chk("mid_flags", {30'h0, overflow, misalign_err}, 0);
        apply(0,1,32'h2C,3,0);
        chk("fresh_valid", 32'(out_valid), 1);
        chk("fresh_data", out_data, 3);
        chk("fresh_offset", 32'(out_offset), 3);
        chk("fresh_count", 32'(fifo_count), 1);
        apply(0,0,0,0,0);
        chk("stall_data", out_data, 3);
        chk("stall_count", 32'(fifo_count), 1);

        // randomized traffic against the model
        apply(1,0,0,0,0);
        for (int n = 0; n < 600; n++) begin
            logic r, w, rd;
            logic [31:0] a;
            r  = $urandom_range(0, 59) == 0;
            w  = $urandom_range(0, 3) != 0;
            rd = $urandom_range(0, 2) == 0;
            case ($urandom_range(0, 3))
                0: a = 32'h20 + 32'(4 * $urandom_range(0, 3));
                1: a = 32'h1C + 32'($urandom_range(0, 23));
                2: a = 32'($urandom_range(0, 32'h60));
                default: a = 32'h24;
            endcase
            apply(r, w, a, $urandom, rd);
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
